mem_access_unit: RTL and testbench
==================================

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have parameter TIMEOUT, default 15: maximum number of cycles mem_req stays high without mem_ack before the access is aborted.
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port MC, input, 2 bits: bit0 MW (memory write), bit1 MR (memory read), taken from the microinstruction.
REQ-005 SHALL have port start, input, 1 bit: microinstruction strobe requesting the access encoded in MC.
REQ-006 SHALL have port addr_in, input, 16 bits: access address (register bank AUXreg).
REQ-007 SHALL have port wdata_in, input, 16 bits: store data (register bank WRcurrent).
REQ-008 SHALL have port mem_req, output, 1 bit: memory request.
REQ-009 SHALL have port mem_we, output, 1 bit: 1 = write, 0 = read; valid while mem_req = 1.
REQ-010 SHALL have ports mem_addr and mem_wdata, output, 16 bits each: latched address and store data.
REQ-011 SHALL have port mem_ack, input, 1 bit: memory completion.
REQ-012 SHALL have port mem_rdata, input, 16 bits: load data, valid when mem_ack = 1.
REQ-013 SHALL have port Mdata, output, 16 bits: load data delivered to the register bank.
REQ-014 SHALL have port workRegWrite, output, 1 bit: one-cycle strobe telling the register bank to write Mdata into the working register.
REQ-015 SHALL have ports busy, done and illegal, output, 1 bit each.
REQ-016 SHALL have port timeout_err, output, 1 bit: sticky timeout flag.

Function
REQ-017 SHALL implement the FSM states IDLE, ACCESS, COMPLETE and ABORT.
REQ-018 In IDLE, start=1 with MC=01 or MC=10 SHALL latch addr_in, wdata_in and the access type, clear timeout_err, and move to ACCESS on the same edge.
REQ-019 In IDLE, start=1 with MC=00 SHALL be ignored: no state change and no outputs.
REQ-020 In IDLE, start=1 with MC=11 SHALL pulse illegal for exactly one cycle and remain in IDLE with no memory access.
REQ-021 In ACCESS, mem_req SHALL be 1, mem_we SHALL equal the latched MW, and mem_addr/mem_wdata SHALL hold the latched values.
REQ-022 In ACCESS, a 16-bit cycle counter SHALL start at 0 on entry and increment each cycle that mem_ack = 0.
REQ-023 In ACCESS, mem_ack=1 SHALL move the FSM to COMPLETE, and for a read SHALL register mem_rdata into Mdata on that edge.
REQ-024 In ACCESS, with mem_ack=0 and counter = TIMEOUT-1, the FSM SHALL move to ABORT; if mem_ack=1 on that same cycle, ack SHALL win.
REQ-025 COMPLETE SHALL last one cycle: done=1, mem_req=0, workRegWrite=1 only for a read; the FSM then returns to IDLE.
REQ-026 ABORT SHALL last one cycle: mem_req=0, timeout_err set, done=1, workRegWrite=0, Mdata unchanged; the FSM then returns to IDLE.
REQ-027 busy SHALL be 1 in ACCESS, COMPLETE and ABORT.
REQ-028 start asserted while busy=1 SHALL be ignored and SHALL NOT be queued.
REQ-029 mem_ack received while not in ACCESS SHALL be ignored.
REQ-030 Latency from the start edge to mem_req=1 SHALL be one cycle.
REQ-031 Latency from the mem_ack sample to done/workRegWrite SHALL be one cycle; minimum access time SHALL be 2 cycles.
REQ-032 Mdata SHALL hold its value until the next completed read.
REQ-033 timeout_err SHALL hold until the next accepted start.

Reset
REQ-034 While rst_n=0, the FSM SHALL be in IDLE and all outputs and latches SHALL be 0, independent of clk.
REQ-035 Reset asserted mid-access SHALL drop mem_req immediately and discard the access, with no done or workRegWrite.
REQ-036 After rst_n deasserts, the first accepted start SHALL be taken on the first rising edge of clk.

Verification
REQ-037 Read test: MC=10, addr_in=0x0040, start 1 cycle, mem_ack after 3 cycles with mem_rdata=0xBEEF -> mem_req high 3 cycles, mem_we=0, mem_addr=0x0040, then done, workRegWrite=1 and Mdata=0xBEEF for 1 cycle.
REQ-038 Write test: MC=01, addr_in=0x0012, wdata_in=0x00F0, mem_ack in the first cycle -> mem_we=1, mem_wdata=0x00F0, done after 2 cycles total, workRegWrite=0, Mdata unchanged.
REQ-039 Timeout test: TIMEOUT=15, read with no mem_ack -> mem_req high exactly 15 cycles, then ABORT with done=1 and timeout_err=1 held; the next valid start clears timeout_err.
REQ-040 Illegal and idle test: MC=11 start -> illegal pulse, busy=0, mem_req=0; MC=00 start -> no activity.
REQ-041 Busy test: a second start during ACCESS with different addr_in -> ignored; mem_addr unchanged; exactly one done.
REQ-042 Reset test: rst_n low in cycle 2 of ACCESS -> mem_req=0 asynchronously, no done; a fresh read afterwards completes normally.

Source files
------------

// File: rtl/mem_access_unit.sv
// mem_access_unit: microcoded memory access sequencer with ack timeout and sticky error flag
module mem_access_unit #(
    parameter int TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  MC,
    input  logic        start,
    input  logic [15:0] addr_in,
    input  logic [15:0] wdata_in,
    output logic        mem_req,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [15:0] mem_rdata,
    output logic [15:0] Mdata,
    output logic        workRegWrite,
    output logic        busy,
    output logic        done,
    output logic        illegal,
    output logic        timeout_err
);
    typedef enum logic [1:0] {IDLE, ACCESS, COMPLETE, ABORT} state_t;

    state_t      r_state, w_next;
    logic [15:0] r_cnt, r_addr, r_wdata, r_mdata;
    logic        r_we, r_terr, r_illegal;
    logic        w_accept, w_expire;

    assign w_accept = (r_state == IDLE) && start && (MC == 2'b01 || MC == 2'b10);
    assign w_expire = (r_cnt == 16'(TIMEOUT - 1));

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    // next-state logic; ack takes priority over an expiring counter
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:     w_next = w_accept ? ACCESS : IDLE;
            ACCESS:   w_next = mem_ack ? COMPLETE : (w_expire ? ABORT : ACCESS);
            default:  w_next = IDLE;
        endcase
    end

    // latches for the access, wait counter, load data and status flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt     <= '0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_mdata   <= '0;
            r_we      <= 1'b0;
            r_terr    <= 1'b0;
            r_illegal <= 1'b0;
        end else begin
            r_illegal <= (r_state == IDLE) && start && (MC == 2'b11);
            if (w_accept) begin
                r_we    <= MC[0];
                r_addr  <= addr_in;
                r_wdata <= wdata_in;
                r_terr  <= 1'b0;
                r_cnt   <= '0;
            end else if (r_state == ACCESS && !mem_ack) begin
                r_cnt <= r_cnt + 16'd1;
            end
            if (r_state == ACCESS && mem_ack && !r_we) r_mdata <= mem_rdata;
            if (r_state == ACCESS && !mem_ack && w_expire) r_terr <= 1'b1;
        end
    end

    // outputs decoded from the current state
    always_comb begin
        mem_req      = (r_state == ACCESS);
        mem_we       = (r_state == ACCESS) && r_we;
        done         = (r_state == COMPLETE) || (r_state == ABORT);
        workRegWrite = (r_state == COMPLETE) && !r_we;
        busy         = (r_state != IDLE);
    end

    assign mem_addr    = r_addr;
    assign mem_wdata   = r_wdata;
    assign Mdata       = r_mdata;
    assign timeout_err = r_terr;
    assign illegal     = r_illegal;
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: randomized self-checking bench for mem_access_unit
module tb_mem_access_unit;
    localparam int TO = 15;

    logic        clk = 0, rst_n = 0;
    logic [1:0]  MC = 0;
    logic        start = 0, mem_ack = 0;
    logic [15:0] addr_in = 0, wdata_in = 0, mem_rdata = 0;
    logic        mem_req, mem_we, workRegWrite, busy, done, illegal, timeout_err;
    logic [15:0] mem_addr, mem_wdata, Mdata;

    int          vec = 0, err = 0;
    logic [15:0] exp_mdata = 0;
    logic        exp_terr = 0;

    mem_access_unit #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .MC(MC), .start(start), .addr_in(addr_in),
        .wdata_in(wdata_in), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata), .Mdata(Mdata),
        .workRegWrite(workRegWrite), .busy(busy), .done(done), .illegal(illegal),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One access: ack arrives in ACCESS cycle d (0-based), d >= TO means no ack.
    // poke=1 fires a second start with a different address during ACCESS.
    task automatic do_access(input logic [1:0] mc, input logic [15:0] a, input logic [15:0] wd,
                             input logic [15:0] rd, input int d, input bit poke);
        int  n, exp_n;
        bit  rd_op, aborted;
        rd_op   = (mc == 2'b10);
        aborted = (d >= TO);
        exp_n   = aborted ? TO : d + 1;
        MC = mc; addr_in = a; wdata_in = wd; start = 1;
        step();
        start = 0; MC = 0;
        exp_terr = 0;
        vec++; if (mem_req !== 1'b1) begin err++; $display("FAIL start_latency mem_req=%b exp=1", mem_req); end
        vec++; if (timeout_err !== 1'b0) begin err++; $display("FAIL terr_clear got=%b exp=0", timeout_err); end
        n = 0;
        while (mem_req === 1'b1 && n < 40) begin
            vec++; if (mem_we !== mc[0]) begin err++; $display("FAIL mem_we cyc=%0d got=%b exp=%b", n, mem_we, mc[0]); end
            vec++; if (mem_addr !== a) begin err++; $display("FAIL mem_addr cyc=%0d got=%h exp=%h", n, mem_addr, a); end
            vec++; if (mem_wdata !== wd) begin err++; $display("FAIL mem_wdata cyc=%0d got=%h exp=%h", n, mem_wdata, wd); end
            vec++; if (busy !== 1'b1 || done !== 1'b0) begin err++; $display("FAIL access_flags cyc=%0d busy=%b done=%b exp 1/0", n, busy, done); end
            mem_ack   = (n == d);
            mem_rdata = (n == d) ? rd : 16'($urandom);
            if (poke && n == 1) begin start = 1; MC = 2'b10; addr_in = ~a; end
            step();
            start = 0; MC = 0; mem_ack = 0;
            n++;
        end
        if (!aborted && rd_op) exp_mdata = rd;
        if (aborted) exp_terr = 1;
        vec++; if (n !== exp_n) begin err++; $display("FAIL req_cycles got=%0d exp=%0d", n, exp_n); end
        vec++; if (done !== 1'b1 || busy !== 1'b1) begin err++; $display("FAIL end_state done=%b busy=%b exp 1/1", done, busy); end
        vec++; if (workRegWrite !== (!aborted && rd_op)) begin err++; $display("FAIL wrw got=%b exp=%b", workRegWrite, !aborted && rd_op); end
        vec++; if (Mdata !== exp_mdata) begin err++; $display("FAIL mdata got=%h exp=%h", Mdata, exp_mdata); end
        vec++; if (timeout_err !== exp_terr) begin err++; $display("FAIL terr got=%b exp=%b", timeout_err, exp_terr); end
        step();
        vec++; if (done !== 1'b0 || busy !== 1'b0 || workRegWrite !== 1'b0 || mem_req !== 1'b0) begin
            err++; $display("FAIL back_idle done=%b busy=%b wrw=%b req=%b exp all 0", done, busy, workRegWrite, mem_req);
        end
        vec++; if (Mdata !== exp_mdata || timeout_err !== exp_terr) begin
            err++; $display("FAIL hold mdata=%h exp=%h terr=%b exp=%b", Mdata, exp_mdata, timeout_err, exp_terr);
        end
    endtask

    task automatic test_reset();
        #2;
        vec++; if ({mem_req, mem_we, busy, done, illegal, timeout_err, workRegWrite} !== 7'b0) begin
            err++; $display("FAIL reset_flags got=%b exp=0", {mem_req, mem_we, busy, done, illegal, timeout_err, workRegWrite});
        end
        vec++; if ({mem_addr, mem_wdata, Mdata} !== 48'b0) begin
            err++; $display("FAIL reset_data got=%h exp=0", {mem_addr, mem_wdata, Mdata});
        end
        #10 rst_n = 1;
        step();
    endtask

    task automatic test_read();
        do_access(2'b10, 16'h0040, 16'h0000, 16'hBEEF, 2, 0);
    endtask

    task automatic test_write();
        do_access(2'b01, 16'h0012, 16'h00F0, 16'h1234, 0, 0);
    endtask

    task automatic test_timeout();
        do_access(2'b10, 16'h0100, 16'h0000, 16'h5555, 99, 0);
        do_access(2'b01, 16'h0101, 16'hA5A5, 16'h0, 14, 0);
    endtask

    task automatic test_illegal_idle();
        MC = 2'b11; start = 1; mem_ack = 1;
        step();
        start = 0; MC = 0;
        vec++; if (illegal !== 1'b1) begin err++; $display("FAIL illegal_pulse got=%b exp=1", illegal); end
        vec++; if (busy !== 1'b0 || mem_req !== 1'b0) begin err++; $display("FAIL illegal_noacc busy=%b req=%b exp 0/0", busy, mem_req); end
        step();
        vec++; if (illegal !== 1'b0) begin err++; $display("FAIL illegal_width got=%b exp=0", illegal); end
        MC = 2'b00; start = 1;
        step();
        start = 0;
        vec++; if ({busy, mem_req, done, illegal} !== 4'b0) begin err++; $display("FAIL mc00 got=%b exp=0", {busy, mem_req, done, illegal}); end
        mem_ack = 0;
        step();
        vec++; if ({busy, done, workRegWrite, illegal} !== 4'b0) begin err++; $display("FAIL idle_ack got=%b exp=0", {busy, done, workRegWrite, illegal}); end
    endtask

    task automatic test_busy();
        do_access(2'b10, 16'h0777, 16'h0000, 16'hC0DE, 4, 1);
        vec++; if (busy !== 1'b0 || mem_req !== 1'b0) begin err++; $display("FAIL not_queued busy=%b req=%b exp 0/0", busy, mem_req); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 25; i++)
            do_access($urandom_range(0, 1) ? 2'b10 : 2'b01, 16'($urandom), 16'($urandom),
                      16'($urandom), $urandom_range(0, 18), $urandom_range(0, 1) == 1);
    endtask

    task automatic test_mid_reset();
        MC = 2'b10; addr_in = 16'h0ABC; start = 1;
        step();
        start = 0; MC = 0;
        step();
        rst_n = 0;
        #1;
        exp_mdata = 0; exp_terr = 0;
        vec++; if (mem_req !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            err++; $display("FAIL async_reset req=%b busy=%b done=%b exp 0", mem_req, busy, done);
        end
        vec++; if (mem_addr !== 16'h0 || Mdata !== 16'h0) begin err++; $display("FAIL reset_latch addr=%h mdata=%h exp 0", mem_addr, Mdata); end
        mem_ack = 1;
        step();
        step();
        mem_ack = 0;
        vec++; if (done !== 1'b0 || workRegWrite !== 1'b0) begin err++; $display("FAIL reset_nodone done=%b wrw=%b exp 0", done, workRegWrite); end
        @(negedge clk);
        rst_n = 1;
        do_access(2'b10, 16'h0ABC, 16'h0000, 16'h9876, 1, 0);
    endtask

    initial begin
        test_reset();
        test_read();
        test_write();
        test_timeout();
        test_illegal_idle();
        test_busy();
        test_random();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vec, err);
        $finish;
    end
endmodule
